input_event_player: RTL and testbench
=====================================

# input_event_player

Drives one monitor input stream (`input_0` / `new_input_0`) from a queued trace of timed events, the hardware counterpart of the bench stimulus that feeds the monitor's event inputs. An upstream source (trace ROM reader, host bridge) pushes (delay, value) pairs through a valid/ready port into an internal FIFO. The block replays them with cycle-exact spacing as single-cycle `new_input_0` pulses. It sits directly in front of the monitor's `input_0` / `new_input_0` ports.

## Interface
- `DATA_W`, 64: width of event value (signed).
- `DELAY_W`, 32: width of inter-event delay field.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `en`  in  1  global enable; low freezes playback (FSM, delay counter, pop, outputs).
- `s_valid`  in  1  trace entry offered.
- `s_ready`  out  1  FIFO can accept; `s_ready = (count != DEPTH)`.
- `s_delay`  in  DELAY_W  idle cycles inserted before this event (unsigned).
- `s_data`  in  DATA_W  event value (signed).
- `input_0`  out  DATA_W  event value; 0 when no pulse.
- `new_input_0`  out  1  one-cycle event strobe.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  `(state != IDLE) || (count != 0)`.

## Operation
- Push: entry written when `s_valid && s_ready` at the rising edge. Independent of `en`.
- FIFO: circular buffer with wrapping rd/wr pointers. Occupancy `count` is registered. Push and pop in the same cycle leave `count` unchanged. No bypass: an entry is poppable at earliest one edge after it is written.
- FSM states: IDLE, WAIT, EMIT. All transitions are gated by `en`.
  - IDLE: if `count != 0`, pop the head, load `cnt <= delay`, go to WAIT.
  - WAIT: if `cnt == 0`, go to EMIT, registering `new_input_0 <= 1` and `input_0 <= data`. Otherwise `cnt <= cnt - 1`.
  - EMIT: clear `new_input_0 <= 0` and `input_0 <= 0`. If `count != 0`, pop the next entry and go to WAIT. Otherwise go to IDLE.
- Outputs are registered. `input_0` is nonzero only while `new_input_0 = 1`.
- `en` low: state, `cnt`, pop, and outputs hold. A pulse in progress is stretched for the low cycles. Push still operates.
- Full FIFO: `s_ready = 0`. A pop in the same cycle does not raise `s_ready` until the next cycle.
- Delay is the full `DELAY_W` range with no saturation. `s_delay = 2^DELAY_W - 1` is legal.

## Timing
- Reset values: `new_input_0 = 0`, `input_0 = 0`, `count = 0`, `s_ready = 1`, `busy = 0`, state IDLE, `cnt = 0`, pointers 0.
- Reset is asynchronous. Outputs go to reset values without a clock edge, and the FIFO contents are discarded. Asserting `rst` mid-WAIT or mid-EMIT abandons the current event.
- Latency from an idle block, with `en = 1`: entry accepted at edge k → popped at k+1 → `new_input_0` high from edge k+2+d to edge k+3+d, where d = `s_delay`.
- Back-to-back queued entries: consecutive pulse rising edges are d+2 cycles apart, d being the second entry's delay. The minimum spacing is 2 cycles, one high and one low. Consecutive events never merge.
- `en` low for n cycles anywhere in the sequence delays all later pulses by exactly n cycles.

## Test plan
- Reset: hold `rst = 1`, toggle inputs → all outputs at reset values. Deassert, push (d=0, 5) → pulse `input_0 = 5` two edges after acceptance. Assert `rst` asynchronously between edges → outputs 0 immediately and `count = 0`.
- Spacing: push (0,1), (0,2), (3,3), (0,4) back-to-back → pulses with values 1, 2, 3, 4, rising edges at t0, t0+2, t0+7, t0+9. Each pulse is exactly one cycle wide; `input_0 = 0` between pulses.
- Full/wrap: push 10 entries with d=100 and `s_valid` held high → exactly 8 accepted, `s_ready = 0`, `count = 8`. After the first pop, `s_ready` rises the next cycle. Drain 20 entries total across the pointer wrap → values out in push order.
- Enable: entry d=10, drop `en` for 4 cycles mid-WAIT → pulse 4 cycles later than nominal. Drop `en` during EMIT for 3 cycles → `new_input_0` high for 4 cycles with the value held.
- Large delay: d = 999 → pulse at edge k+1001. `busy = 1` throughout and 0 one cycle after EMIT when the FIFO is empty.

Source files
------------

// File: rtl/input_event_player_if.sv
// Trace-entry stream from an upstream source (trace ROM reader, host bridge)
// into the event player. Each transfer carries one (delay, value) pair and
// completes when s_valid and s_ready are both high at a rising clock edge.
interface input_event_player_if #(
    parameter int DATA_W  = 64,
    parameter int DELAY_W = 32
);
    logic                      s_valid;
    logic                      s_ready;
    logic        [DELAY_W-1:0] s_delay;
    logic signed [DATA_W-1:0]  s_data;

    // Upstream side: offers entries.
    modport master (
        output s_valid,
        output s_delay,
        output s_data,
        input  s_ready
    );

    // Player side: accepts entries.
    modport slave (
        input  s_valid,
        input  s_delay,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/input_event_player.sv
// Replays a queued trace of (delay, value) events onto a monitor input as
// single-cycle new_input_0 pulses with cycle-exact spacing. Entries arrive
// through a valid/ready port into a circular FIFO. A small FSM pops the head,
// counts out its delay, then emits one pulse before taking the next entry.
module input_event_player #(
    parameter int DATA_W  = 64,
    parameter int DELAY_W = 32,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input_event_player_if.slave        s_if,
    output logic signed [DATA_W-1:0]   input_0,
    output logic                       new_input_0,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EMIT
    } state_t;

    // FIFO storage and bookkeeping
    logic        [DELAY_W-1:0] r_mem_delay [DEPTH];
    logic signed [DATA_W-1:0]  r_mem_data  [DEPTH];
    logic        [PTR_W-1:0]   r_wr_ptr;
    logic        [PTR_W-1:0]   r_rd_ptr;
    logic        [CNT_W-1:0]   r_count;

    // Playback state
    state_t                    r_state;
    logic        [DELAY_W-1:0] r_cnt;
    logic signed [DATA_W-1:0]  r_data;
    logic signed [DATA_W-1:0]  r_input_0;
    logic                      r_new_input_0;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_not_empty;

    assign w_not_empty = (r_count != '0);

    // Full is judged on the registered count, so a pop during a full cycle
    // only frees the slot from the following cycle onward.
    assign s_if.s_ready = (r_count != FULL_CNT);
    assign w_push       = s_if.s_valid && s_if.s_ready;

    // The head leaves the FIFO only when the FSM is ready for a new event.
    // There is no bypass: a freshly written entry is visible one edge later.
    assign w_pop = en && w_not_empty && ((r_state == ST_IDLE) || (r_state == ST_EMIT));

    assign input_0     = r_input_0;
    assign new_input_0 = r_new_input_0;
    assign count       = r_count;
    assign busy        = (r_state != ST_IDLE) || w_not_empty;

    // Write accepted entries into the slot under the write pointer.
    // NOTE: the storage array carries no reset; the pointers and count alone
    // decide which slots hold live entries, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_delay[r_wr_ptr] <= s_if.s_delay;
            r_mem_data[r_wr_ptr]  <= s_if.s_data;
        end
    end

    // Advance the wrapping pointers and keep the occupancy count in step.
    // NOTE: every register here uses <= so all updates read pre-edge values,
    // which is what lets a push and a pop in one cycle cancel cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Playback FSM: pop, count the delay down, emit one pulse; en freezes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_data        <= '0;
            r_input_0     <= '0;
            r_new_input_0 <= 1'b0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cnt   <= r_mem_delay[r_rd_ptr];
                        r_data  <= r_mem_data[r_rd_ptr];
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_new_input_0 <= 1'b1;
                        r_input_0     <= r_data;
                        r_state       <= ST_EMIT;
                    end else begin
                        r_cnt <= r_cnt - DELAY_W'(1);
                    end
                end
                ST_EMIT: begin
                    r_new_input_0 <= 1'b0;
                    r_input_0     <= '0;
                    if (w_pop) begin
                        r_cnt   <= r_mem_delay[r_rd_ptr];
                        r_data  <= r_mem_data[r_rd_ptr];
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_event_player.sv
// Bench for input_event_player. The reference model works per event rather
// than per state: from each entry's acceptance edge and the enable schedule it
// derives the pop edge, the pulse edge and the pulse end edge, then predicts
// every output at every cycle from those timestamps.
module tb_input_event_player;

    localparam int DATA_W  = 64;
    localparam int DELAY_W = 32;
    localparam int DEPTH   = 8;
    localparam int MAXE    = 4096;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     en  = 1'b0;
    logic signed [DATA_W-1:0] input_0;
    logic                     new_input_0;
    logic [$clog2(DEPTH):0]   count;
    logic                     busy;

    input_event_player_if #(.DATA_W(DATA_W), .DELAY_W(DELAY_W)) s_bus ();

    input_event_player #(.DATA_W(DATA_W), .DELAY_W(DELAY_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .s_if        (s_bus),
        .input_0     (input_0),
        .new_input_0 (new_input_0),
        .count       (count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DELAY_W-1:0] d;
        logic [DATA_W-1:0]  v;
    } ent_t;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus state
    ent_t pend[$];
    int   valid_pct;
    bit   en_sched[MAXE];
    int   e_now;

    // Model: per accepted event, the edges at which it is accepted, popped,
    // pulsed, and at which the pulse ends.
    int               ev_a[$];
    int               ev_p[$];
    int               ev_s[$];
    int               ev_end[$];
    logic [DATA_W-1:0] ev_v[$];
    int               last_s;

    // Observed pulses
    int                obs_rise[$];
    logic [DATA_W-1:0] obs_val[$];
    int                obs_width[$];
    int                run_len;
    bit                prev_new;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_en(input int e);
        int k;
        k = e;
        while (k < MAXE - 1 && !en_sched[k]) k++;
        return k;
    endfunction

    function automatic int model_count(input int e);
        int c;
        c = 0;
        foreach (ev_a[i]) begin
            if (ev_a[i] <= e) c++;
            if (ev_p[i] <= e) c--;
        end
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] model_out(input int e, output bit pulse);
        pulse = 1'b0;
        model_out = '0;
        foreach (ev_s[i]) begin
            if (ev_s[i] <= e && e < ev_end[i]) begin
                pulse = 1'b1;
                model_out = ev_v[i];
            end
        end
    endfunction

    function automatic bit model_active(input int e);
        bit act;
        act = 1'b0;
        foreach (ev_p[i]) if (ev_p[i] <= e && e < ev_end[i]) act = 1'b1;
        return act;
    endfunction

    // Record one accepted entry and derive its whole playback timeline.
    task automatic accept(input ent_t x, input int a);
        int p, s, lo;
        lo = (a + 1 > last_s + 1) ? a + 1 : last_s + 1;
        p = next_en(lo);
        s = p;
        for (longint j = 0; j <= longint'(x.d) && s < MAXE; j++) s = next_en(s + 1);
        ev_a.push_back(a);
        ev_p.push_back(p);
        ev_s.push_back(s);
        ev_end.push_back(next_en(s + 1));
        ev_v.push_back(x.v);
        last_s = s;
    endtask

    task automatic sample_and_check();
        int               exp_cnt;
        bit               pulse;
        logic [DATA_W-1:0] exp_val;
        exp_cnt = model_count(e_now);
        exp_val = model_out(e_now, pulse);
        check("count", 64'(count), 64'(exp_cnt));
        check("s_ready", 64'(s_bus.s_ready), 64'(exp_cnt != DEPTH));
        check("new_input_0", 64'(new_input_0), 64'(pulse));
        check("input_0", input_0, exp_val);
        check("busy", 64'(busy), 64'((exp_cnt != 0) || model_active(e_now)));
        if (new_input_0 && !prev_new) begin
            obs_rise.push_back(e_now);
            obs_val.push_back(input_0);
            run_len = 1;
        end else if (new_input_0) begin
            run_len++;
        end else if (prev_new) begin
            obs_width.push_back(run_len);
        end
        prev_new = new_input_0;
    endtask

    // Drive inputs for the next edge, clock it, then check at the falling edge.
    task automatic tick();
        ent_t x;
        bit   v, rdy;
        en  = en_sched[e_now + 1];
        rdy = (model_count(e_now) != DEPTH);
        v   = (pend.size() != 0) && ($urandom_range(99) < valid_pct);
        s_bus.s_valid = v;
        if (v) begin
            x = pend[0];
            s_bus.s_delay = x.d;
            s_bus.s_data  = x.v;
            if (rdy) begin
                void'(pend.pop_front());
                accept(x, e_now + 1);
            end
        end else begin
            s_bus.s_delay = $urandom;
            s_bus.s_data  = {$urandom, $urandom};
        end
        @(posedge clk);
        e_now++;
        @(negedge clk);
        sample_and_check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold reset briefly, clear the model, release on a falling edge.
    task automatic init_phase();
        rst = 1'b1;
        en  = 1'b0;
        s_bus.s_valid = 1'b0;
        repeat (2) @(negedge clk);
        ev_a.delete(); ev_p.delete(); ev_s.delete(); ev_end.delete(); ev_v.delete();
        obs_rise.delete(); obs_val.delete(); obs_width.delete();
        pend.delete();
        foreach (en_sched[i]) en_sched[i] = 1'b1;
        valid_pct = 100;
        last_s    = -1;
        e_now     = 0;
        run_len   = 0;
        prev_new  = 1'b0;
        rst = 1'b0;
        sample_and_check();
    endtask

    function automatic int get_rise(input int i);
        return (i < obs_rise.size()) ? obs_rise[i] : -1;
    endfunction

    function automatic logic [DATA_W-1:0] get_val(input int i);
        return (i < obs_val.size()) ? obs_val[i] : '1;
    endfunction

    function automatic int get_width(input int i);
        return (i < obs_width.size()) ? obs_width[i] : -1;
    endfunction

    initial begin
        s_bus.s_valid = 1'b0;
        s_bus.s_delay = '0;
        s_bus.s_data  = '0;

        // Reset held while inputs toggle: outputs stay at reset values.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en            = 1'($urandom);
            s_bus.s_valid = 1'($urandom);
            s_bus.s_delay = $urandom;
            s_bus.s_data  = {$urandom, $urandom};
            #1;
            check("rst_new", 64'(new_input_0), 64'(0));
            check("rst_input", input_0, 64'(0));
            check("rst_count", 64'(count), 64'(0));
            check("rst_ready", 64'(s_bus.s_ready), 64'(1));
            check("rst_busy", 64'(busy), 64'(0));
        end

        // Single entry (0,5): accepted at edge 1, pulse at edge 3.
        init_phase();
        pend.push_back('{d: 32'd0, v: 64'd5});
        run(8);
        check("first_rise", 64'(get_rise(0)), 64'(3));
        check("first_val", get_val(0), 64'd5);

        // Asynchronous reset while a pulse is high and an entry is queued.
        init_phase();
        pend.push_back('{d: 32'd2, v: 64'd7});
        pend.push_back('{d: 32'd0, v: 64'd8});
        run(5);
        check("pre_rst_new", 64'(new_input_0), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("async_new", 64'(new_input_0), 64'(0));
        check("async_input", input_0, 64'(0));
        check("async_count", 64'(count), 64'(0));
        check("async_busy", 64'(busy), 64'(0));

        // Back-to-back spacing: rises at t0, t0+2, t0+7, t0+9.
        init_phase();
        pend.push_back('{d: 32'd0, v: 64'd1});
        pend.push_back('{d: 32'd0, v: 64'd2});
        pend.push_back('{d: 32'd3, v: 64'd3});
        pend.push_back('{d: 32'd0, v: 64'd4});
        run(20);
        check("gap_1", 64'(get_rise(1) - get_rise(0)), 64'(2));
        check("gap_2", 64'(get_rise(2) - get_rise(0)), 64'(7));
        check("gap_3", 64'(get_rise(3) - get_rise(0)), 64'(9));
        for (int i = 0; i < 4; i++) begin
            check("spacing_val", get_val(i), 64'(i + 1));
            check("spacing_width", 64'(get_width(i)), 64'(1));
        end

        // Full FIFO with playback frozen, then drain 20 entries across the wrap.
        init_phase();
        for (int i = 0; i < 20; i++) pend.push_back('{d: 32'd100, v: 64'(100 + i)});
        for (int i = 1; i <= 12; i++) en_sched[i] = 1'b0;
        run(12);
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_ready", 64'(s_bus.s_ready), 64'(0));
        run(1);
        check("ready_after_pop", 64'(s_bus.s_ready), 64'(1));
        run(2100);
        check("drain_n", 64'(obs_val.size()), 64'(20));
        for (int i = 0; i < 20; i++) check("drain_order", get_val(i), 64'(100 + i));

        // Enable low 4 cycles in WAIT, then 3 cycles in EMIT.
        init_phase();
        pend.push_back('{d: 32'd10, v: 64'd42});
        for (int i = 5; i <= 8; i++) en_sched[i] = 1'b0;
        for (int i = 18; i <= 20; i++) en_sched[i] = 1'b0;
        run(30);
        check("en_rise", 64'(get_rise(0)), 64'(17));
        check("en_width", 64'(get_width(0)), 64'(4));
        check("en_val", get_val(0), 64'd42);

        // Large delay 999: accepted at edge 1, pulse at edge 1002.
        init_phase();
        pend.push_back('{d: 32'd999, v: -64'sd3});
        run(1002);
        check("big_new", 64'(new_input_0), 64'(1));
        check("big_busy", 64'(busy), 64'(1));
        check("big_val", input_0, -64'sd3);
        run(1);
        check("big_idle_busy", 64'(busy), 64'(0));
        check("big_rise", 64'(get_rise(0)), 64'(1002));

        // Maximum delay is accepted and keeps the block busy without a pulse.
        init_phase();
        pend.push_back('{d: '1, v: 64'd9});
        run(40);
        check("max_busy", 64'(busy), 64'(1));
        check("max_no_pulse", 64'(obs_rise.size()), 64'(0));

        // Randomized traffic with random valid gaps and enable drops.
        init_phase();
        valid_pct = 70;
        for (int i = 1; i <= 700; i++) en_sched[i] = ($urandom_range(99) < 85);
        for (int i = 0; i < 60; i++)
            pend.push_back('{d: DELAY_W'($urandom_range(6)), v: {$urandom, $urandom}});
        run(900);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
